// File: rtl/sr_pulse_ctrl.sv
// sr_pulse_ctrl: drive stage for an SR NOR latch.
// Two raw pushbuttons are synchronised, debounced and rising-edge detected.
// Each request becomes a fixed-width S or R pulse. Pulses are mutually exclusive
// and separated by a guard gap, and requests that arrive while busy are queued
// in one pending flag per type.
module sr_pulse_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_COUNT    = 4,
    parameter int unsigned PULSE_LEN   = 2,
    parameter int unsigned GAP_LEN     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_reset,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict
);

    // Channel 0 carries the set button, channel 1 the reset button.
    localparam int unsigned NumCh = 2;

    localparam logic [7:0] DbTarget  = 8'(DB_COUNT);
    localparam logic [3:0] PulseLoad = 4'(PULSE_LEN - 1);
    localparam logic [3:0] GapLoad   = 4'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetPulse,
        StRstPulse,
        StGap
    } state_e;

    // Input conditioning
    logic [NumCh-1:0]                  btn_raw;
    logic [NumCh-1:0][SYNC_STAGES-1:0] sync_q;
    logic [NumCh-1:0][SYNC_STAGES-1:0] sync_d;
    logic [NumCh-1:0]                  sync_out;
    logic [NumCh-1:0]                  db_q;
    logic [NumCh-1:0]                  db_d;
    logic [NumCh-1:0][7:0]             db_cnt_q;
    logic [NumCh-1:0][7:0]             db_cnt_d;
    logic [NumCh-1:0]                  db_prev_q;
    logic [NumCh-1:0]                  req_q;
    logic [NumCh-1:0]                  req_d;
    logic                              req_set;
    logic                              req_rst;

    // Request queueing
    logic pend_set_q;
    logic pend_set_d;
    logic pend_rst_q;
    logic pend_rst_d;
    logic want_set;
    logic want_rst;
    logic start_set;
    logic start_rst;

    // Pulse sequencing
    state_e     state_q;
    state_e     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       s_q;
    logic       s_d;
    logic       r_q;
    logic       r_d;

    assign btn_raw = {btn_reset, btn_set};

    // Shift each raw button into its synchroniser chain; stage 0 is the first flop.
    always_comb begin
        for (int unsigned i = 0; i < NumCh; i++) begin
            sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Debounce: flip only after DB_COUNT consecutive cycles of disagreement.
    always_comb begin
        for (int unsigned i = 0; i < NumCh; i++) begin
            db_d[i]     = db_q[i];
            db_cnt_d[i] = '0;
            if (sync_out[i] != db_q[i]) begin
                if (db_cnt_q[i] + 8'd1 == DbTarget) begin
                    db_d[i]     = ~db_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // A request is a one-cycle strobe on a debounced 0->1 transition.
    always_comb begin
        for (int unsigned i = 0; i < NumCh; i++) begin
            req_d[i] = db_q[i] & ~db_prev_q[i];
        end
    end

    assign req_set = req_q[0];
    assign req_rst = req_q[1];

    // Synchroniser, debouncer and edge-detect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            db_q      <= '0;
            db_cnt_q  <= '0;
            db_prev_q <= '0;
            req_q     <= '0;
        end else begin
            sync_q    <= sync_d;
            db_q      <= db_d;
            db_cnt_q  <= db_cnt_d;
            db_prev_q <= db_q;
            req_q     <= req_d;
        end
    end

    // A request counts as wanted whether it was queued earlier or arrives now.
    assign want_set = pend_set_q | req_set;
    assign want_rst = pend_rst_q | req_rst;

    // Pending flags absorb repeats and clear only when their pulse is launched.
    always_comb begin
        pend_set_d = want_set & ~start_set;
        pend_rst_d = want_rst & ~start_rst;
    end

    // Pending flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_set_q <= 1'b0;
            pend_rst_q <= 1'b0;
        end else begin
            pend_set_q <= pend_set_d;
            pend_rst_q <= pend_rst_d;
        end
    end

    // State, shared pulse/gap counter and registered latch drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
        end
    end

    // Next state: dispatch from idle (reset wins), time the pulse, then the gap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_set = 1'b0;
        start_rst = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (want_rst) begin
                    state_d   = StRstPulse;
                    cnt_d     = PulseLoad;
                    start_rst = 1'b1;
                end else if (want_set) begin
                    state_d   = StSetPulse;
                    cnt_d     = PulseLoad;
                    start_set = 1'b1;
                end
            end
            StSetPulse, StRstPulse: begin
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: S/R are registered copies of the pulse states, so they cannot glitch.
    always_comb begin
        s_d      = (state_d == StSetPulse);
        r_d      = (state_d == StRstPulse);
        busy     = (state_q != StIdle);
        conflict = req_set & req_rst;
    end

    assign S = s_q;
    assign R = r_q;

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// Bench for sr_pulse_ctrl: directed scenarios plus random button activity,
// every cycle compared against a request-scheduling reference model.
module tb_sr_pulse_ctrl;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DB_COUNT    = 4;
    localparam int unsigned PULSE_LEN   = 2;
    localparam int unsigned GAP_LEN     = 1;
    localparam int          Win         = 256;

    logic clk = 1'b0;
    logic rst;
    logic btn_set;
    logic btn_reset;
    logic S;
    logic R;
    logic busy;
    logic conflict;

    int n_checks = 0;
    int n_bad    = 0;
    int cnt_s;
    int cnt_r;
    int cnt_b;
    int cnt_c;

    sr_pulse_ctrl #(
        .SYNC_STAGES(SYNC_STAGES),
        .DB_COUNT   (DB_COUNT),
        .PULSE_LEN  (PULSE_LEN),
        .GAP_LEN    (GAP_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_set  (btn_set),
        .btn_reset(btn_reset),
        .S        (S),
        .R        (R),
        .busy     (busy),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    // Reference model. Timeline: "cycle n" is the interval after rising edge n.
    // Expected outputs are kept in a circular schedule indexed by cycle.
    bit m_hist[2][$];
    bit m_db[2];
    int m_run[2];
    bit m_rose[2];
    bit m_req[2];
    bit m_pend[2];
    int idle_at = 0;
    int cyc     = 0;
    bit exp_s[Win];
    bit exp_r[Win];
    bit exp_busy[Win];
    bit exp_conf[Win];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_hist[c].delete();
                m_db[c]   = 1'b0;
                m_run[c]  = 0;
                m_rose[c] = 1'b0;
                m_pend[c] = 1'b0;
            end
            idle_at = cyc;
            for (int j = 0; j < Win; j++) begin
                exp_s[j]    = 1'b0;
                exp_r[j]    = 1'b0;
                exp_busy[j] = 1'b0;
                exp_conf[j] = 1'b0;
            end
        end else begin
            bit raw[2];
            bit sv;
            int p;
            cyc = cyc + 1;
            p = (cyc + Win - 1) % Win;
            exp_s[p]    = 1'b0;
            exp_r[p]    = 1'b0;
            exp_busy[p] = 1'b0;
            exp_conf[p] = 1'b0;
            raw[0] = btn_set;
            raw[1] = btn_reset;
            for (int c = 0; c < 2; c++) begin
                // The debouncer sees the button as sampled SYNC_STAGES edges ago.
                sv = (m_hist[c].size() == SYNC_STAGES) ? m_hist[c][0] : 1'b0;
                m_hist[c].push_back(raw[c]);
                if (m_hist[c].size() > SYNC_STAGES) void'(m_hist[c].pop_front());
                // A rise detected at the previous edge is a request in this cycle.
                m_req[c]  = m_rose[c];
                m_rose[c] = 1'b0;
                if (sv != m_db[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == DB_COUNT) begin
                        m_db[c]   = ~m_db[c];
                        m_run[c]  = 0;
                        m_rose[c] = m_db[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            exp_conf[cyc % Win] = m_req[0] & m_req[1];
            m_pend[0] = m_pend[0] | m_req[0];
            m_pend[1] = m_pend[1] | m_req[1];
            if (cyc >= idle_at && (m_pend[0] || m_pend[1])) begin
                bit is_rst;
                is_rst = m_pend[1];
                m_pend[is_rst ? 1 : 0] = 1'b0;
                for (int j = 1; j <= int'(PULSE_LEN); j++) begin
                    if (is_rst) exp_r[(cyc + j) % Win] = 1'b1;
                    else        exp_s[(cyc + j) % Win] = 1'b1;
                end
                for (int j = 1; j <= int'(PULSE_LEN + GAP_LEN); j++) begin
                    exp_busy[(cyc + j) % Win] = 1'b1;
                end
                idle_at = cyc + 1 + int'(PULSE_LEN + GAP_LEN);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc,
                     $time);
        end
    endtask

    task automatic clr_cnt();
        cnt_s = 0;
        cnt_r = 0;
        cnt_b = 0;
        cnt_c = 0;
    endtask

    // Advance n cycles, checking every output against the model at each falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (S === 1'b1)        cnt_s++;
            if (R === 1'b1)        cnt_r++;
            if (busy === 1'b1)     cnt_b++;
            if (conflict === 1'b1) cnt_c++;
            if (rst) begin
                check_eq("rst_s", S, 0);
                check_eq("rst_r", R, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_conflict", conflict, 0);
            end else begin
                check_eq("s", S, exp_s[cyc % Win]);
                check_eq("r", R, exp_r[cyc % Win]);
                check_eq("busy", busy, exp_busy[cyc % Win]);
                check_eq("conflict", conflict, exp_conf[cyc % Win]);
            end
            check_eq("s_r_exclusive", S & R, 0);
        end
    endtask

    initial begin
        int  first;
        bit  found;
        rst       = 1'b1;
        btn_set   = 1'b1;
        btn_reset = 1'b0;
        clr_cnt();

        // Reset held with the set button pressed, then latency and width after release.
        step(3);
        check_eq("reset_hold_s", cnt_s, 0);
        check_eq("reset_hold_busy", cnt_b, 0);
        rst = 1'b0;
        clr_cnt();
        first = -1;
        for (int e = 0; e < 20; e++) begin
            step(1);
            if (S === 1'b1 && first < 0) first = e;
        end
        check_eq("latency", first, SYNC_STAGES + DB_COUNT + 1);
        check_eq("first_pulse_len", cnt_s, PULSE_LEN);

        // Bounce shorter than the debounce window must be ignored.
        btn_set = 1'b0;
        step(15);
        clr_cnt();
        for (int i = 0; i < 10; i++) begin
            btn_set = ~btn_set;
            step(2);
        end
        btn_set = 1'b0;
        step(15);
        check_eq("bounce_s", cnt_s, 0);
        check_eq("bounce_busy", cnt_b, 0);

        // Clean set press, then a clean reset press 30 cycles later.
        clr_cnt();
        btn_set = 1'b1;
        step(12);
        btn_set = 1'b0;
        step(30);
        btn_reset = 1'b1;
        step(12);
        btn_reset = 1'b0;
        step(15);
        check_eq("clean_s_len", cnt_s, PULSE_LEN);
        check_eq("clean_r_len", cnt_r, PULSE_LEN);
        check_eq("clean_busy", cnt_b, 2 * (PULSE_LEN + GAP_LEN));
        check_eq("clean_conflict", cnt_c, 0);

        // Both buttons on the same edge.
        clr_cnt();
        btn_set   = 1'b1;
        btn_reset = 1'b1;
        step(20);
        check_eq("simul_conflict", cnt_c, 1);
        check_eq("simul_s_len", cnt_s, PULSE_LEN);
        check_eq("simul_r_len", cnt_r, PULSE_LEN);
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        step(15);

        // Reset request lands while the set pulse is in progress and must queue.
        clr_cnt();
        btn_set = 1'b1;
        step(1);
        btn_reset = 1'b1;
        step(25);
        check_eq("queue_s_len", cnt_s, PULSE_LEN);
        check_eq("queue_r_len", cnt_r, PULSE_LEN);
        check_eq("queue_busy", cnt_b, 2 * (PULSE_LEN + GAP_LEN));
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        step(15);

        // Asynchronous reset during the first S cycle.
        btn_set = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            @(posedge clk);
            #1;
            if (S === 1'b1) found = 1'b1;
        end
        check_eq("s_seen_before_rst", found, 1);
        rst = 1'b1;
        #1;
        check_eq("async_drop_s", S, 0);
        check_eq("async_drop_busy", busy, 0);
        btn_set = 1'b0;
        step(3);
        rst = 1'b0;
        clr_cnt();
        step(25);
        check_eq("post_rst_s", cnt_s, 0);
        check_eq("post_rst_r", cnt_r, 0);

        // Random button activity, including bounce, overlap and queueing.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) btn_set = ~btn_set;
            if ($urandom_range(0, 9) == 0) btn_reset = ~btn_reset;
            step(1);
        end
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        step(30);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_pulse_ctrl.md
Name: sr_pulse_ctrl

Overview:
- Upstream drive stage for the SR NOR latch.
- Takes two raw, bouncy pushbutton inputs, then synchronises, debounces and edge-detects them.
- Emits fixed-width, mutually exclusive S and R pulses, so the latch never sees S=R=1 or a glitch.
- Queues requests that arrive while a pulse or guard gap is in progress.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (legal values 2..4).
- DB_COUNT, 4, consecutive cycles the synchronised input must differ from its debounced value before the debounced value flips (legal values 1..255).
- PULSE_LEN, 2, cycles S or R is held high per request (legal values 1..15).
- GAP_LEN, 1, minimum idle cycles with S=R=0 after any pulse before the next pulse starts (legal values 1..15).

Ports:
- clk  input  1  system clock; every register is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- btn_set  input  1  raw set button, asynchronous to clk.
- btn_reset  input  1  raw reset button, asynchronous to clk.
- S  output  1  registered set drive to the latch.
- R  output  1  registered reset drive to the latch.
- busy  output  1  high in any state other than IDLE.
- conflict  output  1  one-cycle flag: set and reset requests arrived in the same cycle.

Behaviour:
- Reset:
  - rst=1 immediately clears every output and every internal register: synchronisers, debounced values, debounce counters, pending flags and pulse/gap counters.
  - State returns to IDLE.
  - Asserting rst mid-pulse drops S/R asynchronously.
  - After rst falls, the debounced values start at 0. A button already held high therefore produces a request once it has been debounced.
- Synchroniser: each button passes through SYNC_STAGES flip-flops. Only the last stage feeds the debouncer.
- Debouncer, per input:
  - An 8-bit counter increments while sync != debounced.
  - The counter clears in any cycle where sync == debounced.
  - When the counter would reach DB_COUNT, the debounced value toggles and the counter clears.
- Request: the debounced value rising 0->1 produces a one-cycle request (req_set / req_rst). Falling edges produce nothing.
- Pending flags pend_set and pend_rst:
  - Set by a request in any state.
  - Cleared when the corresponding pulse starts.
  - A second request of the same type while its flag is pending is absorbed; there is no count.
- Same-cycle requests: if req_set and req_rst occur in the same cycle, conflict=1 for exactly that cycle and both pending flags are set.
- Arbitration: reset has priority over set whenever both are pending.
- State machine (S and R are registered from the state and counter):
  - IDLE:
    - If pend_rst is set or a request arrives this cycle, go to RST_PULSE (reset wins) or SET_PULSE.
    - The output rises on the next clock edge.
    - The pulse counter loads PULSE_LEN-1.
  - SET_PULSE:
    - S=1, R=0.
    - The counter decrements each cycle. At 0, go to GAP and load the gap counter with GAP_LEN-1.
  - RST_PULSE: R=1, S=0; otherwise the same as SET_PULSE.
  - GAP:
    - S=R=0.
    - The counter decrements each cycle. At 0, return to IDLE.
    - IDLE dispatches a pending request in its first cycle.
- Invariants:
  - S and R are never high in the same cycle.
  - S and R never switch directly from one to the other; at least GAP_LEN zero cycles separate them.
  - Each pulse is exactly PULSE_LEN cycles.
- Latency: a clean step on a raw input, first sampled at clock edge 0, gives S/R high starting at edge SYNC_STAGES+DB_COUNT+1. With default parameters this is edge 7.

Test Plan:
- Reset: hold rst=1 for 3 cycles with btn_set=1 -> S=R=busy=conflict=0 throughout. After release, S rises at edge 7 and stays high for exactly 2 cycles.
- Bounce rejection: toggle btn_set every 2 cycles for 20 cycles, then hold at 0 -> S never asserts and busy stays 0.
- Clean set, then reset 30 cycles later -> exactly 2 cycles of S=1, later exactly 2 cycles of R=1, and busy high for 3 cycles per request.
- Simultaneous: raise both buttons on the same edge -> conflict=1 for one cycle. R is high for 2 cycles, then S=R=0 for 1 cycle, then S is high for 2 cycles; S and R never overlap.
- Queueing: raise btn_reset while S is mid-pulse -> the S pulse completes at full length, the gap is observed, then R pulses for 2 cycles.
- Reset mid-pulse: assert rst during the first cycle of S=1 -> S drops immediately (no clock edge needed), and no pulse follows deassertion while the buttons are low.
